obi_uart_irq_ctrl: RTL and testbench

OBI_UART_IRQ_CTRL -- requirements
Module: obi_uart_irq_ctrl

---
 rtl/obi_uart_pkg.sv | 73 +++++++
 rtl/obi_uart_rx_timeout.sv | 54 +++++
 rtl/obi_uart_irq_ctrl.sv | 116 +++++++++++
 tb/tb_obi_uart_irq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_uart_pkg.sv
// Shared types, interrupt ids and RX trigger encoding for the UART IRQ block.
package obi_uart_pkg;

    typedef struct packed {
        logic [3:0] unused;
        logic       mstat;
        logic       rlstat;
        logic       thr_empty;
        logic       dtr;
    } ier_t;

    typedef struct packed {
        logic [1:0] rx_fifo_tl;
        logic [2:0] reserved;
        logic       tx_fifo_rst;
        logic       rx_fifo_rst;
        logic       fifo_en;
    } fcr_t;

    typedef struct packed {
        logic       dlab;
        logic       set_break;
        logic       stick_par;
        logic       even_par;
        logic       par_en;
        logic       stop_bits;
        logic [1:0] word_len;
    } lcr_t;

    typedef struct packed {
        logic [1:0] fifos_en;
        logic       unused5;
        logic       unused4;
        logic [2:0] id;
        logic       status;
    } isr_bits_t;

    localparam logic [2:0] IrqIdRls  = 3'b011;
    localparam logic [2:0] IrqIdRda  = 3'b010;
    localparam logic [2:0] IrqIdCto  = 3'b110;
    localparam logic [2:0] IrqIdThre = 3'b001;
    localparam logic [2:0] IrqIdMs   = 3'b000;
    localparam logic [2:0] IrqIdNone = 3'b000;

    localparam logic [1:0] RxTl1  = 2'b00;
    localparam logic [1:0] RxTl4  = 2'b01;
    localparam logic [1:0] RxTl8  = 2'b10;
    localparam logic [1:0] RxTl14 = 2'b11;

    function automatic logic [4:0] rx_trigger(input fcr_t fcr);
        logic [4:0] trig;
        trig = 5'd1;
        if (fcr.fifo_en) begin
            unique case (fcr.rx_fifo_tl)
                RxTl1:   trig = 5'd1;
                RxTl4:   trig = 5'd4;
                RxTl8:   trig = 5'd8;
                RxTl14:  trig = 5'd14;
                default: trig = 5'd1;
            endcase
        end
        return trig;
    endfunction

    // 64 baud ticks per bit time of a full character frame
    function automatic logic [9:0] cto_threshold(input lcr_t lcr);
        logic [3:0] char_bits;
        char_bits = 4'd7 + {2'b00, lcr.word_len} + {3'b000, lcr.par_en}
                  + {3'b000, lcr.stop_bits};
        return {char_bits, 6'b000000};
    endfunction

endpackage

// File: rtl/obi_uart_rx_timeout.sv
// RX character-timeout counter: counts baud ticks while RX data waits unread.
module obi_uart_rx_timeout
    import obi_uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  lcr_t       lcr_i,
    input  logic [4:0] rx_level_i,
    input  logic       rx_push_i,
    input  logic       rx_read_i,
    input  logic       baud_tick_i,
    output logic       cto_o
);

    logic [9:0] cnt_q, cnt_d;
    logic [9:0] thresh;
    logic       flag_q, flag_d;
    logic       clr;
    logic [3:0] unused_lcr;

    assign unused_lcr = {lcr_i.dlab, lcr_i.set_break, lcr_i.stick_par, lcr_i.even_par};

    // threshold follows LCR live, so a mid-count change re-targets the count
    always_comb begin
        thresh = cto_threshold(lcr_i);
        clr    = rx_push_i | rx_read_i | (rx_level_i == 5'd0);
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (clr) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end else begin
            if (cnt_q >= thresh) begin
                cnt_d = thresh;
            end else if (baud_tick_i) begin
                cnt_d = cnt_q + 10'd1;
            end
            flag_d = flag_q | (cnt_d >= thresh);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign cto_o = flag_q;

endmodule

// File: rtl/obi_uart_irq_ctrl.sv
// 16550-style interrupt prioritiser producing ISR and IRQ.
// Define OBI_UART_RX_TIMEOUT_EN to include the RX character-timeout source.
module obi_uart_irq_ctrl
    import obi_uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  ier_t       ier_i,
    input  fcr_t       fcr_i,
    input  lcr_t       lcr_i,
    input  logic [3:0] lsr_err_i,
    input  logic       thr_empty_i,
    input  logic [3:0] msr_delta_i,
    input  logic [4:0] rx_level_i,
    input  logic       rx_push_i,
    input  logic       baud_tick_i,
    input  logic       obi_read_isr_i,
    input  logic       obi_read_rhr_i,
    input  logic       obi_write_thr_i,
    output isr_bits_t  isr_o,
    output logic       irq_o
);

    isr_bits_t isr_q, isr_d;
    logic      irq_q, irq_d;
    logic      thre_pend_q, thre_pend_d;
    logic      thr_empty_q, thr_empty_d;
    logic      ier_thre_q, ier_thre_d;
    logic      cto_flag;
    logic      src_rls, src_rda, src_cto, src_thre, src_ms;
    logic      thre_set, thre_clr;
    logic [8:0] unused_cfg;

    assign unused_cfg = {ier_i.unused, fcr_i.reserved,
                         fcr_i.tx_fifo_rst, fcr_i.rx_fifo_rst};

`ifdef OBI_UART_RX_TIMEOUT_EN
    obi_uart_rx_timeout u_rx_timeout (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .lcr_i       (lcr_i),
        .rx_level_i  (rx_level_i),
        .rx_push_i   (rx_push_i),
        .rx_read_i   (obi_read_rhr_i),
        .baud_tick_i (baud_tick_i),
        .cto_o       (cto_flag)
    );
`else
    logic unused_cto;
    assign unused_cto = ^{lcr_i, rx_push_i, baud_tick_i, obi_read_rhr_i};
    assign cto_flag   = 1'b0;
`endif

    // THRE pending is used from its next-state so set/clear land with one cycle latency
    always_comb begin
        thr_empty_d = thr_empty_i;
        ier_thre_d  = ier_i.thr_empty;
        thre_set    = (thr_empty_i & ~thr_empty_q)
                    | (thr_empty_i & ier_i.thr_empty & ~ier_thre_q);
        thre_clr    = obi_write_thr_i
                    | (obi_read_isr_i & ~isr_q.status & (isr_q.id == IrqIdThre));
        thre_pend_d = thre_pend_q;
        if (thre_clr) begin
            thre_pend_d = 1'b0;
        end else if (thre_set) begin
            thre_pend_d = 1'b1;
        end
    end

    always_comb begin
        src_rls  = ier_i.rlstat & (|lsr_err_i);
        src_rda  = ier_i.dtr & (rx_level_i >= rx_trigger(fcr_i));
        src_cto  = ier_i.dtr & cto_flag;
        src_thre = ier_i.thr_empty & thre_pend_d;
        src_ms   = ier_i.mstat & (|msr_delta_i);

        isr_d          = '0;
        isr_d.fifos_en = fcr_i.fifo_en ? 2'b11 : 2'b00;
        isr_d.id       = IrqIdNone;
        isr_d.status   = 1'b0;
        if (src_rls) begin
            isr_d.id = IrqIdRls;
        end else if (src_rda) begin
            isr_d.id = IrqIdRda;
        end else if (src_cto) begin
            isr_d.id = IrqIdCto;
        end else if (src_thre) begin
            isr_d.id = IrqIdThre;
        end else if (src_ms) begin
            isr_d.id = IrqIdMs;
        end else begin
            isr_d.status = 1'b1;
        end
        irq_d = ~isr_d.status;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            isr_q       <= 8'h01;
            irq_q       <= 1'b0;
            thre_pend_q <= 1'b0;
            thr_empty_q <= 1'b0;
            ier_thre_q  <= 1'b0;
        end else begin
            isr_q       <= isr_d;
            irq_q       <= irq_d;
            thre_pend_q <= thre_pend_d;
            thr_empty_q <= thr_empty_d;
            ier_thre_q  <= ier_thre_d;
        end
    end

    assign isr_o = isr_q;
    assign irq_o = irq_q;

endmodule

// File: tb/tb_obi_uart_irq_ctrl.sv
// Directed self-checking bench for obi_uart_irq_ctrl.
module tb_obi_uart_irq_ctrl;
    import obi_uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    ier_t       ier;
    fcr_t       fcr;
    lcr_t       lcr;
    logic [3:0] lsr_err;
    logic       thr_empty;
    logic [3:0] msr_delta;
    logic [4:0] rx_level;
    logic       rx_push;
    logic       baud_tick;
    logic       rd_isr;
    logic       rd_rhr;
    logic       wr_thr;
    isr_bits_t  isr;
    logic       irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    obi_uart_irq_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ier_i           (ier),
        .fcr_i           (fcr),
        .lcr_i           (lcr),
        .lsr_err_i       (lsr_err),
        .thr_empty_i     (thr_empty),
        .msr_delta_i     (msr_delta),
        .rx_level_i      (rx_level),
        .rx_push_i       (rx_push),
        .baud_tick_i     (baud_tick),
        .obi_read_isr_i  (rd_isr),
        .obi_read_rhr_i  (rd_rhr),
        .obi_write_thr_i (wr_thr),
        .isr_o           (isr),
        .irq_o           (irq)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic baud(input int n);
        for (int i = 0; i < n; i++) begin
            baud_tick = 1'b1;
            tick(1);
            baud_tick = 1'b0;
            tick(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ier = '0; fcr = '0; lcr = '0; lsr_err = '0;
        thr_empty = 1'b0; msr_delta = '0; rx_level = '0; rx_push = 1'b0;
        baud_tick = 1'b0; rd_isr = 1'b0; rd_rhr = 1'b0; wr_thr = 1'b0;
        tick(3);
        n_cmp++;
        if (isr !== 8'h01) begin
            n_bad++; $display("FAIL reset_isr got=%h exp=01", isr);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++; $display("FAIL reset_irq got=%b exp=0", irq);
        end
        rst = 1'b0;
        fcr = 8'h01;
        tick(1);
        n_cmp++;
        if (isr !== 8'hC1) begin
            n_bad++; $display("FAIL fifo_en_isr got=%h exp=c1", isr);
        end
    endtask

    task automatic test_priority;
        fcr = 8'hC1; ier = 8'h0F; lsr_err = 4'b0001; rx_level = 5'd14;
        tick(1);
        n_cmp++;
        if (isr !== 8'hC6 || irq !== 1'b1) begin
            n_bad++; $display("FAIL prio_rls got=%h/%b exp=c6/1", isr, irq);
        end
        lsr_err = 4'b0000;
        tick(1);
        n_cmp++;
        if (isr !== 8'hC4) begin
            n_bad++; $display("FAIL prio_rda got=%h exp=c4", isr);
        end
        rx_level = 5'd13;
        tick(1);
        n_cmp++;
        if (isr !== 8'hC1 || irq !== 1'b0) begin
            n_bad++; $display("FAIL rda_below_tl got=%h/%b exp=c1/0", isr, irq);
        end
        fcr = 8'h41; rx_level = 5'd4;
        tick(1);
        n_cmp++;
        if (isr !== 8'hC4) begin
            n_bad++; $display("FAIL rda_tl4 got=%h exp=c4", isr);
        end
        fcr = 8'hC0; rx_level = 5'd1;
        tick(1);
        n_cmp++;
        if (isr !== 8'h04) begin
            n_bad++; $display("FAIL rda_nofifo got=%h exp=04", isr);
        end
        rx_level = 5'd0;
        tick(1);
        n_cmp++;
        if (isr !== 8'h01) begin
            n_bad++; $display("FAIL rda_empty got=%h exp=01", isr);
        end
        ier = 8'h00; fcr = 8'hC1;
        tick(1);
    endtask

    task automatic test_thre;
        ier = 8'h02;
        tick(1);
        thr_empty = 1'b1;
        tick(1);
        n_cmp++;
        if (isr !== 8'hC2 || irq !== 1'b1) begin
            n_bad++; $display("FAIL thre_set got=%h/%b exp=c2/1", isr, irq);
        end
        rd_isr = 1'b1;
        tick(1);
        rd_isr = 1'b0;
        n_cmp++;
        if (isr !== 8'hC1 || irq !== 1'b0) begin
            n_bad++; $display("FAIL thre_isr_clr got=%h/%b exp=c1/0", isr, irq);
        end
        tick(2);
        n_cmp++;
        if (isr !== 8'hC1) begin
            n_bad++; $display("FAIL thre_no_reedge got=%h exp=c1", isr);
        end
        thr_empty = 1'b0;
        tick(1);
        thr_empty = 1'b1; wr_thr = 1'b1;
        tick(1);
        wr_thr = 1'b0;
        n_cmp++;
        if (isr !== 8'hC1 || irq !== 1'b0) begin
            n_bad++; $display("FAIL thre_clr_wins got=%h/%b exp=c1/0", isr, irq);
        end
        tick(1);
        n_cmp++;
        if (isr !== 8'hC1) begin
            n_bad++; $display("FAIL thre_clr_hold got=%h exp=c1", isr);
        end
        ier = 8'h00;
        tick(1);
        ier = 8'h02;
        tick(1);
        n_cmp++;
        if (isr !== 8'hC2) begin
            n_bad++; $display("FAIL thre_ier_rise got=%h exp=c2", isr);
        end
        wr_thr = 1'b1;
        tick(1);
        wr_thr = 1'b0; thr_empty = 1'b0;
        n_cmp++;
        if (isr !== 8'hC1) begin
            n_bad++; $display("FAIL thre_wr_clr got=%h exp=c1", isr);
        end
        ier = 8'h00;
        tick(1);
    endtask

    task automatic test_ms;
        ier = 8'h08; msr_delta = 4'b0001;
        tick(1);
        n_cmp++;
        if (isr !== 8'hC0 || irq !== 1'b1) begin
            n_bad++; $display("FAIL ms_set got=%h/%b exp=c0/1", isr, irq);
        end
        msr_delta = 4'b0000;
        tick(1);
        n_cmp++;
        if (isr !== 8'hC1 || irq !== 1'b0) begin
            n_bad++; $display("FAIL ms_drop got=%h/%b exp=c1/0", isr, irq);
        end
        ier = 8'h00;
    endtask

    task automatic test_cto;
        ier = 8'h01; fcr = 8'hC1; lcr = 8'h03; rx_level = 5'd1;
        tick(1);
`ifdef OBI_UART_RX_TIMEOUT_EN
        baud(639);
        tick(2);
        n_cmp++;
        if (isr !== 8'hC1) begin
            n_bad++; $display("FAIL cto_early got=%h exp=c1", isr);
        end
        baud(1);
        tick(2);
        n_cmp++;
        if (isr !== 8'hCC || irq !== 1'b1) begin
            n_bad++; $display("FAIL cto_640 got=%h/%b exp=cc/1", isr, irq);
        end
        baud(10);
        n_cmp++;
        if (isr !== 8'hCC) begin
            n_bad++; $display("FAIL cto_sat got=%h exp=cc", isr);
        end
        rd_rhr = 1'b1;
        tick(1);
        rd_rhr = 1'b0;
        tick(1);
        n_cmp++;
        if (isr !== 8'hC1 || irq !== 1'b0) begin
            n_bad++; $display("FAIL cto_rhr_clr got=%h/%b exp=c1/0", isr, irq);
        end
        baud(400);
        lcr = 8'h00;
        baud(47);
        tick(2);
        n_cmp++;
        if (isr !== 8'hC1) begin
            n_bad++; $display("FAIL cto_lcr_early got=%h exp=c1", isr);
        end
        baud(1);
        tick(2);
        n_cmp++;
        if (isr !== 8'hCC) begin
            n_bad++; $display("FAIL cto_lcr_448 got=%h exp=cc", isr);
        end
        rx_level = 5'd0;
        tick(2);
        n_cmp++;
        if (isr !== 8'hC1) begin
            n_bad++; $display("FAIL cto_empty_clr got=%h exp=c1", isr);
        end
`else
        baud(700);
        n_cmp++;
        if (isr !== 8'hC1) begin
            n_bad++; $display("FAIL nocto_700 got=%h exp=c1", isr);
        end
        baud(1300);
        n_cmp++;
        if (isr !== 8'hC1 || irq !== 1'b0) begin
            n_bad++; $display("FAIL nocto_2000 got=%h/%b exp=c1/0", isr, irq);
        end
        rx_level = 5'd0;
`endif
        ier = 8'h00; lcr = 8'h00;
        tick(1);
    endtask

    task automatic test_reset_midway;
        ier = 8'h0A; msr_delta = 4'b0010; thr_empty = 1'b1;
        tick(2);
        n_cmp++;
        if (isr !== 8'hC2 || irq !== 1'b1) begin
            n_bad++; $display("FAIL pre_rst got=%h/%b exp=c2/1", isr, irq);
        end
        rst = 1'b1; thr_empty = 1'b0; msr_delta = 4'b0000;
        tick(1);
        n_cmp++;
        if (isr !== 8'h01 || irq !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst got=%h/%b exp=01/0", isr, irq);
        end
        rst = 1'b0;
        tick(1);
        n_cmp++;
        if (isr !== 8'hC1 || irq !== 1'b0) begin
            n_bad++; $display("FAIL post_rst got=%h/%b exp=c1/0", isr, irq);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_thre();
        test_ms();
        test_cto();
        test_reset_midway();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
